// File: rtl/cpu_dbg_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the run/step/breakpoint controller: state codes and
// debounce lengths for simulation and for the board.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BREAK = 2'd3
    } dbg_state_t;

    localparam int DB_CYCLES_SIM   = 4;
    localparam int DB_CYCLES_BOARD = 500000;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
`timescale 1ns/1ps
// Signal bundle between the board/core side and the step controller.
// master = board buttons, switches and core; slave = the controller.
interface cpu_step_ctrl_if #(
    parameter int AW = 32
);
    logic          btn_step;
    logic          btn_run;
    logic          bp_en;
    logic [AW-1:0] bp_addr;
    logic [AW-1:0] pc;
    logic          clr_cnt;
    logic          cpu_en;
    logic          halted;
    logic          at_bp;
    logic [31:0]   cycle_cnt;
    logic [1:0]    state_o;

    modport master (
        output btn_step, btn_run, bp_en, bp_addr, pc, clr_cnt,
        input  cpu_en, halted, at_bp, cycle_cnt, state_o
    );

    modport slave (
        input  btn_step, btn_run, bp_en, bp_addr, pc, clr_cnt,
        output cpu_en, halted, at_bp, cycle_cnt, state_o
    );
endinterface

// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int DBW       = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic           sync1_reg;
    logic           sync2_reg;
    logic           level_reg;
    logic [DBW-1:0] cnt_reg;
    logic           mismatch;
    logic           accept;

    assign mismatch = sync2_reg ^ level_reg;
    // The DB_CYCLES-th consecutive differing sample flips the level.
    assign accept   = mismatch && (cnt_reg == DBW'(DB_CYCLES - 1));
    assign pulse    = accept & ~level_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            if (!mismatch) begin
                cnt_reg <= '0;
            end else if (accept) begin
                cnt_reg   <= '0;
                level_reg <= ~level_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cpu_step_ctrl.sv
`timescale 1ns/1ps
// Gates the core clock-enable from debounced step/run buttons, halts on a PC
// breakpoint and counts enabled cycles for the display.
module cpu_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int DBW       = 20,
    parameter int AW        = 32
) (
    input logic            CCLK,
    input logic            rst_n,
    cpu_step_ctrl_if.slave bus
);
    logic [1:0]    btn_raw;
    logic [1:0]    btn_pulse;
    logic          step_p;
    logic          run_p;
    logic [AW-1:0] pc_now;
    logic [AW-1:0] bp_now;
    logic          bp_hit;

    dbg_state_t    state_reg;
    dbg_state_t    state_next;
    logic          cpu_en_reg;
    logic          halted_reg;
    logic          at_bp_reg;
    logic          bp_skip_reg;
    logic [31:0]   cycle_cnt_reg;

    assign btn_raw = {bus.btn_run, bus.btn_step};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .DBW       (DBW)
        ) u_db (
            .clk   (CCLK),
            .rst_n (rst_n),
            .btn   (btn_raw[gi]),
            .pulse (btn_pulse[gi])
        );
    end

    assign step_p = btn_pulse[0];
    assign run_p  = btn_pulse[1];

    assign pc_now = bus.pc;
    assign bp_now = bus.bp_addr;
    // Skip lets the core leave a breakpoint without re-hitting the same PC.
    assign bp_hit = bus.bp_en & (pc_now == bp_now) & ~bp_skip_reg;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (run_p)       state_next = ST_RUN;
                else if (step_p) state_next = ST_STEP;
            end
            ST_STEP: state_next = ST_IDLE;
            ST_RUN: begin
                if (run_p)       state_next = ST_IDLE;
                else if (bp_hit) state_next = ST_BREAK;
            end
            ST_BREAK: begin
                if (run_p)       state_next = ST_RUN;
                else if (step_p) state_next = ST_STEP;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cpu_en_reg    <= 1'b0;
            halted_reg    <= 1'b1;
            at_bp_reg     <= 1'b0;
            bp_skip_reg   <= 1'b0;
            cycle_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cpu_en_reg <= (state_next == ST_STEP) || (state_next == ST_RUN);
            halted_reg <= (state_next == ST_IDLE) || (state_next == ST_BREAK);
            at_bp_reg  <= (state_next == ST_BREAK);

            if ((state_reg == ST_BREAK) && (state_next != ST_BREAK))
                bp_skip_reg <= 1'b1;
            else if (cpu_en_reg)
                bp_skip_reg <= 1'b0;

            if (bus.clr_cnt)
                cycle_cnt_reg <= '0;
            else if (cpu_en_reg)
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        end
    end

    assign bus.cpu_en    = cpu_en_reg;
    assign bus.halted    = halted_reg;
    assign bus.at_bp     = at_bp_reg;
    assign bus.cycle_cnt = cycle_cnt_reg;
    assign bus.state_o   = state_reg;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for cpu_step_ctrl: a cycle-level reference model pushes the
// expected outputs per clock and a monitor pops and compares them.
module tb_cpu_step_ctrl;
    localparam int DB = 4;
    localparam int AW = 32;
    localparam int S_IDLE = 0, S_STEP = 1, S_RUN = 2, S_BREAK = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_step_ctrl_if #(.AW(AW)) bus ();

    cpu_step_ctrl #(
        .DB_CYCLES (DB),
        .DBW       (20),
        .AW        (AW)
    ) dut (
        .CCLK  (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        en;
        logic [1:0]  st;
        logic        halted;
        logic        at_bp;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model state.
    bit          model_on  = 0;
    bit          m_rst_req = 0;
    bit          m_d1[2], m_d2[2], m_lvl[2];
    int          m_run[2];
    int          m_state = S_IDLE;
    bit          m_en = 0, m_skip = 0;
    logic [31:0] m_cnt = 0;
    logic [31:0] m_pc_new = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
        end
        m_state = S_IDLE; m_en = 0; m_skip = 0; m_cnt = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs as driven.
    task automatic model_edge();
        bit   raw[2];
        bit   p[2];
        bit   hit;
        int   nx;
        exp_t e;
        if (m_rst_req) begin
            model_reset();
            m_rst_req = 0;
        end
        raw[0] = bus.btn_step;
        raw[1] = bus.btn_run;
        for (int b = 0; b < 2; b++) begin
            p[b] = 0;
            // A level is accepted after DB consecutive differing synced samples.
            if (m_d2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_lvl[b] = m_d2[b];
                    m_run[b] = 0;
                    p[b]     = m_lvl[b];
                end
            end else begin
                m_run[b] = 0;
            end
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
        end
        hit = bus.bp_en && (bus.pc == bus.bp_addr) && !m_skip;
        nx  = m_state;
        case (m_state)
            S_IDLE:  if (p[1]) nx = S_RUN; else if (p[0]) nx = S_STEP;
            S_STEP:  nx = S_IDLE;
            S_RUN:   if (p[1]) nx = S_IDLE; else if (hit) nx = S_BREAK;
            default: if (p[1]) nx = S_RUN; else if (p[0]) nx = S_STEP;
        endcase
        if (bus.clr_cnt) m_cnt = 0;
        else if (m_en)   m_cnt = m_cnt + 1;
        if (m_state == S_BREAK && nx != S_BREAK) m_skip = 1;
        else if (m_en)                           m_skip = 0;
        m_state = nx;
        m_en    = (nx == S_STEP) || (nx == S_RUN);
        // The core model moves to the next word while enabled (16-word loop).
        if (m_en) m_pc_new = (bus.pc + 32'd4) & 32'h3C;
        e.en     = m_en;
        e.st     = 2'(m_state);
        e.halted = (m_state == S_IDLE) || (m_state == S_BREAK);
        e.at_bp  = (m_state == S_BREAK);
        e.cnt    = m_cnt;
        q.push_back(e);
    endtask

    always @(posedge clk) if (model_on) model_edge();

    // Monitor: the DUT presents a fresh output set every cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk("cpu_en",    32'(bus.cpu_en),  32'(e.en));
            chk("state",     32'(bus.state_o), 32'(e.st));
            chk("halted",    32'(bus.halted),  32'(e.halted));
            chk("at_bp",     32'(bus.at_bp),   32'(e.at_bp));
            chk("cycle_cnt", bus.cycle_cnt,    e.cnt);
        end
    end

    task automatic cyc(input bit s, input bit r, input bit clr);
        @(negedge clk);
        bus.btn_step = s;
        bus.btn_run  = r;
        bus.clr_cnt  = clr;
        bus.pc       = m_pc_new;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic press(input bit s, input bit r, input int w);
        for (int i = 0; i < w; i++) cyc(s, r, 0);
        cyc(0, 0, 0);
    endtask

    task automatic wait_state(input int tgt, input int budget, input string nm);
        for (int i = 0; i < budget && m_state != tgt; i++) cyc(0, 0, 0);
        chk(nm, 32'(bus.state_o), 32'(tgt));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_en"}, 32'(bus.cpu_en),  32'd0);
        chk({tag, "_halted"}, 32'(bus.halted),  32'd1);
        chk({tag, "_at_bp"},  32'(bus.at_bp),   32'd0);
        chk({tag, "_cnt"},    bus.cycle_cnt,    32'd0);
        chk({tag, "_state"},  32'(bus.state_o), 32'(S_IDLE));
    endtask

    initial begin
        int first_en, en_ones;
        int seg_s, seg_r;
        bit vs, vr;
        bus.btn_step = 0; bus.btn_run = 0; bus.bp_en = 0;
        bus.bp_addr = 0; bus.pc = 0; bus.clr_cnt = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n    = 1'b1;
        model_on = 1;
        idle(2);

        // Clean 10-cycle step press: one enable, seen on the 6th negedge after.
        first_en = -1; en_ones = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(i < 10, 0, 0);
            if (i > 0 && bus.cpu_en) begin
                en_ones++;
                if (first_en < 0) first_en = i;
            end
        end
        chk("step_latency", 32'(first_en), 32'd6);
        chk("step_pulses",  32'(en_ones),  32'd1);
        chk("step_cnt",     bus.cycle_cnt, 32'd1);
        chk("step_halted",  32'(bus.halted), 32'd1);

        // Bounce then hold: exactly one more enable.
        cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        idle(8);
        chk("bounce_only_cnt", bus.cycle_cnt, 32'd1);
        press(1, 0, 10);
        idle(10);
        chk("bounce_hold_cnt", bus.cycle_cnt, 32'd2);

        // Run into a breakpoint at 0x20 starting from pc 0.
        bus.bp_en = 1; bus.bp_addr = 32'h20; m_pc_new = 0;
        idle(1);
        press(0, 1, 6);
        wait_state(S_BREAK, 100, "bp_reach");
        chk("bp_pc",     bus.pc,              32'h20);
        chk("bp_at_bp",  32'(bus.at_bp),      32'd1);
        chk("bp_cpu_en", 32'(bus.cpu_en),     32'd0);
        chk("bp_cnt",    bus.cycle_cnt,       32'd10);

        // Step off the breakpoint, then run round the loop back into it.
        press(1, 0, 8);
        idle(10);
        chk("bp_step_pc",    bus.pc,          32'h24);
        chk("bp_step_state", 32'(bus.state_o), 32'(S_IDLE));
        press(0, 1, 6);
        wait_state(S_BREAK, 200, "bp_rehit");
        chk("bp_rehit_pc", bus.pc, 32'h20);

        // Leave BREAK via run, then stop in IDLE.
        press(0, 1, 6);
        idle(8);
        bus.bp_en = 0;
        press(0, 1, 6);
        idle(10);

        // Coincident presses in IDLE: run wins.
        press(1, 1, 6);
        idle(10);
        chk("both_state", 32'(bus.state_o), 32'(S_RUN));
        press(0, 1, 6);
        idle(10);
        chk("stop_state",  32'(bus.state_o), 32'(S_IDLE));
        chk("stop_cpu_en", 32'(bus.cpu_en),  32'd0);

        // Asynchronous reset mid-run.
        press(0, 1, 6);
        idle(6);
        #2;
        rst_n = 1'b0; m_rst_req = 1;
        #0.5;
        chk_reset_vals("async_rst");
        #0.5;
        rst_n = 1'b1;
        idle(4);

        // Clear while counting.
        press(0, 1, 6);
        idle(6);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("clr_cnt", bus.cycle_cnt, 32'd0);
        press(0, 1, 6);
        idle(10);

        // Wrap from all-ones.
        force dut.cycle_cnt_reg = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_reg;
        press(1, 0, 8);
        idle(10);
        chk("wrap_cnt", bus.cycle_cnt, 32'd0);

        // Random bouncing, breakpoint moves and clears.
        bus.bp_en = 1;
        seg_s = 0; seg_r = 0; vs = 0; vr = 0;
        for (int i = 0; i < 1500; i++) begin
            if (seg_s == 0) begin vs = 1'($urandom_range(0, 1)); seg_s = $urandom_range(1, 9); end
            if (seg_r == 0) begin vr = 1'($urandom_range(0, 1)); seg_r = $urandom_range(1, 12); end
            seg_s--; seg_r--;
            cyc(vs, vr, $urandom_range(0, 47) == 0);
            if ($urandom_range(0, 15) == 0) bus.bp_addr = 32'($urandom_range(0, 15)) * 32'd4;
            if ($urandom_range(0, 63) == 0) bus.bp_en = ~bus.bp_en;
        end
        idle(12);
        model_on = 0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
Run/step/breakpoint controller that sequences the MIPS core on the board. It debounces the step and run push-buttons and emits a one-cycle clock-enable per step or a continuous enable in run mode. It halts the core on a PC breakpoint and counts executed cycles for the LCD/LED display. It sits between the board buttons and the core's clock-enable input in mips_top.

Parameters:
DB_CYCLES, 16, consecutive stable samples needed to accept a button level change. Use 4 in simulation, about 500000 on the board.
DBW, 20, width of the debounce counter. Must satisfy 2^DBW > DB_CYCLES.
AW, 32, width of the PC and breakpoint address.

Ports:
CCLK  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
btn_step  in  1  raw step button (BTNS); asynchronous, bouncy.
btn_run  in  1  raw run/halt toggle button (BTNN); asynchronous, bouncy.
bp_en  in  1  breakpoint enable (switch); treated as quasi-static.
bp_addr  in  AW  breakpoint PC value.
pc  in  AW  current PC of the core; valid every cycle.
clr_cnt  in  1  synchronous clear of cycle_cnt.
cpu_en  out  1  core clock-enable; the core advances one instruction per cycle while high.
halted  out  1  high in IDLE and BREAK.
at_bp  out  1  high in BREAK.
cycle_cnt  out  32  number of cycles with cpu_en high; wraps modulo 2^32.
state_o  out  2  current state encoding, for debug display.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cpu_en=0, halted=1, at_bp=0, cycle_cnt=0, bp_skip=0. Synchronizer and debounced levels are all 0.
- Input conditioning, per button:
  - 2-flop synchronizer, then debouncer.
  - The counter increments while the synced level differs from the debounced level, and resets to 0 when they match.
  - When the counter reaches DB_CYCLES-1, the debounced level flips and the counter clears.
  - A rising edge of the debounced level gives a 1-cycle pulse (step_p, run_p).
  - Latency from a clean raw edge to the pulse is 2 + DB_CYCLES cycles. Glitches shorter than DB_CYCLES produce no pulse.
- bp_hit = bp_en & (pc == bp_addr) & ~bp_skip. This is combinational on the current pc.
- State machine (IDLE=0, STEP=1, RUN=2, BREAK=3). cpu_en is a registered Moore output, high exactly in STEP and RUN.
  - IDLE: run_p -> RUN; else step_p -> STEP. Run has priority when both pulses arrive in the same cycle.
  - STEP: lasts exactly one cycle (one cpu_en pulse), then -> IDLE. Pulses arriving during STEP are dropped.
  - RUN:
    - run_p -> IDLE.
    - Else bp_hit -> BREAK. The instruction at bp_addr does not execute: the transition is decided in the cycle pc equals bp_addr, and cpu_en drops in the next cycle.
    - Otherwise stay in RUN. step_p is ignored.
  - BREAK: run_p -> RUN; else step_p -> STEP. Either exit sets bp_skip=1.
- bp_skip clears after the first cpu_en cycle that follows its setting. This lets the core move past the breakpoint; the same address re-hits on the next pass.
- Breakpoints are not checked in STEP or IDLE.
- cycle_cnt: +1 on each cycle with cpu_en=1. clr_cnt has priority over the increment. Wraps from FFFF_FFFF to 0.
- Changing bp_addr mid-RUN takes effect on the next cycle's compare.
- halted = (state==IDLE) | (state==BREAK). at_bp = (state==BREAK).

Decomposition:
- Shared package cpu_dbg_pkg holds:
  - state encodings ST_IDLE/ST_STEP/ST_RUN/ST_BREAK (2 bits);
  - default DB_CYCLES values for simulation and the board.
- One sub-module, btn_debounce (sync + debounce + rising-edge pulse). It is instantiated twice, for step and run.

Test Plan (DB_CYCLES=4):
1. Reset, then a btn_step pulse 10 cycles wide -> exactly one cpu_en=1 cycle, 6 cycles after the raw edge; cycle_cnt=1; state back to IDLE (halted=1).
2. btn_step bounce of 0-1-0-1 with 1-cycle segments, then held high 10 cycles -> exactly one cpu_en pulse; the bounce alone gives none.
3. btn_run pulse, with pc incrementing by 4 from 0 and bp_en=1, bp_addr=0x20 -> cpu_en high from the RUN entry. BREAK is entered the cycle after pc=0x20, with at_bp=1 and cpu_en=0. Verify cycle_cnt.
4. From BREAK at 0x20, btn_step -> one cpu_en cycle with no re-break and pc becomes 0x24. Then btn_run -> RUN continues past 0x24. When pc returns to 0x20 later, BREAK is entered again.
5. btn_step and btn_run debounced pulses coincident in IDLE -> RUN, not STEP. btn_run again -> IDLE, cpu_en=0.
6. rst_n low for 1 ns mid-RUN -> all outputs return to their reset values immediately (asynchronously). clr_cnt asserted in the same cycle as cpu_en=1 -> cycle_cnt=0. Preload cycle_cnt to FFFF_FFFF (via force), then one step -> 0.
